// File: rtl/hp_glitch_gen_pkg.sv
// Shared types and default sizing for the glitch generator and its cycle counter.
package hp_pkg;

   localparam int HP_CNT_W = 8;
   localparam int HP_WIN   = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DELAY,
      ST_PULSE,
      ST_WATCH,
      ST_GAP,
      ST_DONE
   } hp_state_e;

endpackage

// File: rtl/hp_glitch_gen_cycle_cnt.sv
// Loadable down-counter shared by every timed phase; o_zero marks the last cycle of a phase.
module hp_cycle_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_value,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_value;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/hp_glitch_gen.sv
// Glitch sequencer: injects timed pulses onto a detector data path and scores whether
// the detector raised Alarm for each pulse.
module hp_glitch_gen import hp_pkg::*; #(
   parameter int CNT_W = HP_CNT_W,
   parameter int WIN   = HP_WIN
) (
   input  logic             CK,
   input  logic             RST_N,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] delay,
   input  logic [CNT_W-1:0] width,
   input  logic [CNT_W-1:0] gap,
   input  logic [CNT_W-1:0] count,
   input  logic             Alarm,
   output logic             glitch,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] hits,
   output logic [CNT_W-1:0] misses
);

   localparam logic [CNT_W-1:0] WIN_M1 = CNT_W'(WIN - 1);

   hp_state_e        r_state;
   hp_state_e        w_nextState;
   logic [CNT_W-1:0] r_width;
   logic [CNT_W-1:0] r_gap;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_pulsesLeft;
   logic [CNT_W-1:0] r_hits;
   logic [CNT_W-1:0] r_misses;
   logic             r_alarmSeen;
   logic             r_glitch;
   logic             r_busy;
   logic             r_done;
   logic             w_cntLoad;
   logic [CNT_W-1:0] w_cntValue;
   logic             w_cntZero;
   logic             w_pulseDone;
   logic [CNT_W-1:0] w_pulseLen;

   hp_cycle_cnt #(.W(CNT_W)) u_cnt (
      .clk     (CK),
      .rst_n   (RST_N),
      .i_load  (w_cntLoad),
      .i_value (w_cntValue),
      .o_zero  (w_cntZero)
   );

   // The counter holds "cycles remaining minus one", so width=0 still yields one pulse cycle.
   assign w_pulseLen = (r_width == '0) ? '0 : r_width - 1'b1;

   always_comb begin
      w_nextState = r_state;
      w_cntLoad   = 1'b0;
      w_cntValue  = '0;
      w_pulseDone = 1'b0;
      if (abort) begin
         w_nextState = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  w_nextState = ST_DELAY;
                  w_cntLoad   = 1'b1;
                  w_cntValue  = delay;
               end
            end
            ST_DELAY: begin
               if (r_count == '0) begin
                  w_nextState = ST_DONE;
               end else if (w_cntZero) begin
                  w_nextState = ST_PULSE;
                  w_cntLoad   = 1'b1;
                  w_cntValue  = w_pulseLen;
               end
            end
            ST_PULSE: begin
               if (w_cntZero) begin
                  w_nextState = ST_WATCH;
                  w_cntLoad   = 1'b1;
                  w_cntValue  = WIN_M1;
               end
            end
            ST_WATCH: begin
               if (w_cntZero) begin
                  w_pulseDone = 1'b1;
                  if (r_pulsesLeft > CNT_W'(1)) begin
                     w_cntLoad = 1'b1;
                     if (r_gap == '0) begin
                        w_nextState = ST_PULSE;
                        w_cntValue  = w_pulseLen;
                     end else begin
                        w_nextState = ST_GAP;
                        w_cntValue  = r_gap - 1'b1;
                     end
                  end else begin
                     w_nextState = ST_DONE;
                  end
               end
            end
            ST_GAP: begin
               if (w_cntZero) begin
                  w_nextState = ST_PULSE;
                  w_cntLoad   = 1'b1;
                  w_cntValue  = w_pulseLen;
               end
            end
            ST_DONE: w_nextState = ST_IDLE;
            default: w_nextState = ST_IDLE;
         endcase
      end
   end

   // Outputs are registered from the next state so they track the state register exactly.
   always_ff @(posedge CK or negedge RST_N) begin
      if (!RST_N) begin
         r_state      <= ST_IDLE;
         r_width      <= '0;
         r_gap        <= '0;
         r_count      <= '0;
         r_pulsesLeft <= '0;
         r_hits       <= '0;
         r_misses     <= '0;
         r_alarmSeen  <= 1'b0;
         r_glitch     <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_state  <= w_nextState;
         r_glitch <= (w_nextState == ST_PULSE);
         r_busy   <= (w_nextState != ST_IDLE);
         r_done   <= (w_nextState == ST_DONE);

         if (r_state == ST_IDLE && start && !abort) begin
            r_width      <= width;
            r_gap        <= gap;
            r_count      <= count;
            r_pulsesLeft <= count;
            r_hits       <= '0;
            r_misses     <= '0;
         end

         if (w_nextState == ST_PULSE && r_state != ST_PULSE) begin
            r_alarmSeen <= 1'b0;
         end else if ((r_state == ST_PULSE || r_state == ST_WATCH) && Alarm) begin
            r_alarmSeen <= 1'b1;
         end

         // Alarm in the final WATCH cycle still counts, hence the direct OR with Alarm.
         if (w_pulseDone) begin
            r_pulsesLeft <= r_pulsesLeft - 1'b1;
            if (r_alarmSeen || Alarm) begin
               if (r_hits != '1) r_hits <= r_hits + 1'b1;
            end else begin
               if (r_misses != '1) r_misses <= r_misses + 1'b1;
            end
         end
      end
   end

   assign glitch = r_glitch;
   assign busy   = r_busy;
   assign done   = r_done;
   assign hits   = r_hits;
   assign misses = r_misses;

endmodule

// File: tb/tb_hp_glitch_gen.sv
// Directed bench for hp_glitch_gen: a table of whole sequences plus hand-written abort,
// reset and start/abort-collision cases, with a toy detector closing the Alarm loop.
module tb_hp_glitch_gen;

   localparam int CNT_W      = 8;
   localparam int WIN        = 4;
   localparam int CYC_BUDGET = 60;
   localparam int NUM_VECS   = 8;

   logic             CK;
   logic             RST_N;
   logic             start;
   logic             abort;
   logic [CNT_W-1:0] delay;
   logic [CNT_W-1:0] width;
   logic [CNT_W-1:0] gap;
   logic [CNT_W-1:0] count;
   logic             alarmIn;
   logic             glitch;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] hits;
   logic [CNT_W-1:0] misses;

   logic tbAlarm;
   logic useDet;
   logic detInv;
   logic detData;
   logic detAlarm;

   int checkCount;
   int errorCount;

   typedef struct {
      int dly;
      int wid;
      int gp;
      int cnt;
      int alarmK;
      bit useDet;
      bit inv;
      int expRise;
      int expGlitch;
      int expDone;
      int expBusy;
      int expHits;
      int expMisses;
   } vec_t;

   vec_t vecs[NUM_VECS];

   hp_glitch_gen #(.CNT_W(CNT_W), .WIN(WIN)) dut (
      .CK     (CK),
      .RST_N  (RST_N),
      .start  (start),
      .abort  (abort),
      .delay  (delay),
      .width  (width),
      .gap    (gap),
      .count  (count),
      .Alarm  (alarmIn),
      .glitch (glitch),
      .busy   (busy),
      .done   (done),
      .hits   (hits),
      .misses (misses)
   );

   // Free-running 100 MHz clock.
   initial CK = 1'b0;
   always #5 CK = ~CK;

   // Toy phase detector: the glitch is XORed onto a toggling data bit, and the detector
   // flags any cycle where the observed bit differs from the clean one, for either polarity.
   always @(posedge CK) begin
      detData  <= ~detData;
      detAlarm <= ((detData ^ detInv ^ glitch) != (detData ^ detInv));
   end

   assign alarmIn = useDet ? detAlarm : tbAlarm;

   function automatic vec_t mkVec(input int d, input int w, input int g, input int c,
                                  input int ak, input bit ud, input bit iv,
                                  input int er, input int eg, input int ed, input int eb,
                                  input int eh, input int em);
      vec_t v;
      v.dly = d; v.wid = w; v.gp = g; v.cnt = c; v.alarmK = ak;
      v.useDet = ud; v.inv = iv;
      v.expRise = er; v.expGlitch = eg; v.expDone = ed; v.expBusy = eb;
      v.expHits = eh; v.expMisses = em;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Runs one whole sequence from a negedge with the DUT idle. Sample k is taken at the
   // negedge after the k-th posedge following the start edge (k=0 is the start edge).
   task automatic applyStimulus(input int idx);
      vec_t v;
      int   firstRise;
      int   glitchCnt;
      int   doneCycle;
      int   doneCnt;
      int   busyCnt;
      v         = vecs[idx];
      firstRise = -1;
      glitchCnt = 0;
      doneCycle = -1;
      doneCnt   = 0;
      busyCnt   = 0;
      useDet    = v.useDet;
      detInv    = v.inv;
      tbAlarm   = 1'b0;
      delay     = CNT_W'(v.dly);
      width     = CNT_W'(v.wid);
      gap       = CNT_W'(v.gp);
      count     = CNT_W'(v.cnt);
      start     = 1'b1;
      for (int k = 0; k < CYC_BUDGET; k++) begin
         @(negedge CK);
         start = 1'b0;
         if (glitch) begin
            if (firstRise < 0) firstRise = k;
            glitchCnt++;
         end
         if (done) begin
            if (doneCycle < 0) doneCycle = k;
            doneCnt++;
         end
         if (busy) busyCnt++;
         tbAlarm = (k == v.alarmK);
         delay   = CNT_W'($urandom);
         width   = CNT_W'($urandom);
         gap     = CNT_W'($urandom);
         count   = CNT_W'($urandom);
      end
      tbAlarm = 1'b0;
      useDet  = 1'b0;
      checkOutput($sformatf("v%0d first glitch cycle", idx), firstRise, v.expRise);
      checkOutput($sformatf("v%0d glitch cycles", idx), glitchCnt, v.expGlitch);
      checkOutput($sformatf("v%0d done cycle", idx), doneCycle, v.expDone);
      checkOutput($sformatf("v%0d done strobes", idx), doneCnt, 1);
      checkOutput($sformatf("v%0d busy cycles", idx), busyCnt, v.expBusy);
      checkOutput($sformatf("v%0d hits", idx), hits, v.expHits);
      checkOutput($sformatf("v%0d misses", idx), misses, v.expMisses);
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;
      detData    = 1'b0;
      detAlarm   = 1'b0;
      detInv     = 1'b0;
      useDet     = 1'b0;
      tbAlarm    = 1'b0;
      RST_N      = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      delay      = '0;
      width      = '0;
      gap        = '0;
      count      = '0;

      //                 d  w  g  c  alarmK det inv rise glt done busy hit miss
      vecs[0] = mkVec(3, 2, 0, 1, -1,    0,  0,   4,  2,  10,  11,  0,  1);
      vecs[1] = mkVec(0, 2, 5, 3, 15,    0,  0,   1,  6,  29,  30,  1,  2);
      vecs[2] = mkVec(5, 3, 1, 0, -1,    0,  0,  -1,  0,   1,   2,  0,  0);
      vecs[3] = mkVec(1, 0, 0, 2,  7,    0,  0,   2,  2,  12,  13,  1,  1);
      vecs[4] = mkVec(2, 3, 2, 2,  9,    0,  0,   3,  6,  19,  20,  1,  1);
      vecs[5] = mkVec(2, 3, 2, 2, 10,    0,  0,   3,  6,  19,  20,  0,  2);
      vecs[6] = mkVec(0, 1, 0, 8, -1,    1,  0,   1,  8,  41,  42,  8,  0);
      vecs[7] = mkVec(0, 1, 0, 8, -1,    1,  1,   1,  8,  41,  42,  8,  0);

      #1;
      checkOutput("reset glitch", glitch, 0);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset done", done, 0);
      checkOutput("reset hits", hits, 0);
      checkOutput("reset misses", misses, 0);
      @(negedge CK);
      @(negedge CK);
      RST_N = 1'b1;
      @(negedge CK);

      for (int i = 0; i < NUM_VECS; i++) begin
         applyStimulus(i);
      end

      // Abort in the 3rd cycle of the second width-10 pulse (pulse 2 occupies samples 15..24).
      delay = 8'd0; width = 8'd10; gap = 8'd0; count = 8'd2; start = 1'b1;
      @(negedge CK);
      start = 1'b0;
      repeat (17) @(negedge CK);
      checkOutput("pre-abort glitch", glitch, 1);
      checkOutput("pre-abort misses", misses, 1);
      abort = 1'b1;
      @(negedge CK);
      abort = 1'b0;
      checkOutput("abort glitch", glitch, 0);
      checkOutput("abort busy", busy, 0);
      checkOutput("abort done", done, 0);
      checkOutput("abort hits held", hits, 0);
      checkOutput("abort misses held", misses, 1);
      delay = 8'd0; width = 8'd1; gap = 8'd0; count = 8'd1; start = 1'b1;
      @(negedge CK);
      start = 1'b0;
      checkOutput("restart busy", busy, 1);
      checkOutput("restart misses cleared", misses, 0);
      repeat (15) @(negedge CK);
      checkOutput("restart idle", busy, 0);

      // Reset asserted between clock edges while the second pulse is high.
      delay = 8'd0; width = 8'd5; gap = 8'd0; count = 8'd2; start = 1'b1;
      @(negedge CK);
      start = 1'b0;
      repeat (11) @(negedge CK);
      checkOutput("pre-reset glitch", glitch, 1);
      checkOutput("pre-reset misses", misses, 1);
      #2 RST_N = 1'b0;
      #1;
      checkOutput("async reset glitch", glitch, 0);
      checkOutput("async reset busy", busy, 0);
      checkOutput("async reset done", done, 0);
      checkOutput("async reset hits", hits, 0);
      checkOutput("async reset misses", misses, 0);
      @(negedge CK);
      RST_N = 1'b1;
      @(negedge CK);

      // start and abort together in IDLE must leave the sequencer idle.
      delay = 8'd0; width = 8'd1; gap = 8'd0; count = 8'd1;
      start = 1'b1; abort = 1'b1;
      @(negedge CK);
      start = 1'b0; abort = 1'b0;
      checkOutput("start+abort busy", busy, 0);
      @(negedge CK);
      checkOutput("start+abort glitch", glitch, 0);
      checkOutput("start+abort busy later", busy, 0);

      // First start after a mid-run reset behaves as from cold.
      applyStimulus(0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
